// File: rtl/debounce_sync.sv
// Level-input conditioner: multi-flop synchroniser followed by a 4-state debounce FSM
// producing a clean level, its complement, and one-cycle rise/fall pulses.
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic qb,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [1:0] ST_LOW   = 2'd0;
  localparam logic [1:0] CHK_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] CHK_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync_p0;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_q;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_busy;

  logic                   w_s;
  logic [1:0]             w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_q_nxt;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;

  assign w_s = r_sync_p0[SYNC_STAGES-1];

  // Any reversal of the synced level during qualification falls back to the stable state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      ST_LOW: begin
        if (w_s) begin
          w_state_nxt = CHK_HIGH;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      CHK_HIGH: begin
        if (!w_s) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
          w_q_nxt     = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!w_s) begin
          w_state_nxt = CHK_LOW;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      CHK_LOW: begin
        if (w_s) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
          w_q_nxt     = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_cnt_nxt   = '0;
        w_q_nxt     = 1'b0;
      end
    endcase
  end

  // Synchroniser stage and FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_p0 <= '0;
      r_state   <= ST_LOW;
      r_cnt     <= '0;
      r_q       <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_sync_p0 <= {r_sync_p0[SYNC_STAGES-2:0], din};
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_q       <= w_q_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_busy    <= (w_state_nxt == CHK_HIGH) || (w_state_nxt == CHK_LOW);
    end
  end

  assign q    = r_q;
  assign qb   = ~r_q;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = r_busy;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: vector table, hand-built corner sequences and random
// stimulus compared against a run-length model of the debounce rule.
module tb_debounce_sync;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic reset = 1'b0;
  logic din = 1'b0;
  logic q, qb, rise, fall, busy;

  int total = 0;
  int bad   = 0;

  // Reference model: din history, current level and length of the opposing run
  logic hist[$];
  logic m_q, m_rise, m_fall, m_busy;
  int   m_run;

  typedef struct {
    logic din;
    logic q;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;
  vec_t vecs[$];

  debounce_sync #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .q(q),
    .qb(qb),
    .rise(rise),
    .fall(fall),
    .busy(busy)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_q    = 1'b0;
    m_run  = 0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_busy = 1'b0;
  endtask

  // The level seen by the filter at an edge is din as sampled SYNC edges earlier
  // (zero until that many edges have elapsed since reset). A new level is accepted
  // once DEB consecutive samples disagree with the current one.
  task automatic model_step(input logic d);
    logic s;
    hist.push_front(d);
    if (hist.size() > SYNC + 1) void'(hist.pop_back());
    s = (hist.size() > SYNC) ? hist[SYNC] : 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s != m_q) begin
      m_run++;
      if (m_run == DEB) begin
        m_q    = s;
        m_rise = s;
        m_fall = ~s;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
    m_busy = (m_run != 0);
  endtask

  task automatic tick(input logic d);
    din = d;
    @(posedge clk);
    #1;
    model_step(d);
    check("mdl_q", q, m_q);
    check("mdl_qb", qb, ~m_q);
    check("mdl_rise", rise, m_rise);
    check("mdl_fall", fall, m_fall);
    check("mdl_busy", busy, m_busy);
  endtask

  task automatic add(input logic d, input logic eq, input logic er, input logic ef, input logic eb);
    vec_t v;
    v.din = d; v.q = eq; v.rise = er; v.fall = ef; v.busy = eb;
    vecs.push_back(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_q"}, q, 1'b0);
    check({tag, "_qb"}, qb, 1'b1);
    check({tag, "_rise"}, rise, 1'b0);
    check({tag, "_fall"}, fall, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    // Edges counted from reset release: rise at 6, aborted low glitch, then fall at 22
    add(1,0,0,0,0); add(1,0,0,0,0); add(1,0,0,0,1); add(1,0,0,0,1);
    add(1,0,0,0,1); add(1,1,1,0,0); add(1,1,0,0,0); add(1,1,0,0,0);
    add(0,1,0,0,0); add(0,1,0,0,0); add(0,1,0,0,1); add(1,1,0,0,1);
    add(1,1,0,0,1); add(1,1,0,0,0); add(1,1,0,0,0); add(1,1,0,0,0);
    add(0,1,0,0,0); add(0,1,0,0,0); add(0,1,0,0,1); add(0,1,0,0,1);
    add(0,1,0,0,1); add(0,0,0,1,0); add(0,0,0,0,0); add(0,0,0,0,0);

    // Asynchronous reset with the clock stopped and din unknown
    din = 1'bx;
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    model_reset();

    clk_run = 1'b1;
    din = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (vecs[i]) begin
      tick(vecs[i].din);
      check($sformatf("tbl%0d_q", i), q, vecs[i].q);
      check($sformatf("tbl%0d_qb", i), qb, ~vecs[i].q);
      check($sformatf("tbl%0d_rise", i), rise, vecs[i].rise);
      check($sformatf("tbl%0d_fall", i), fall, vecs[i].fall);
      check($sformatf("tbl%0d_busy", i), busy, vecs[i].busy);
    end

    // Reset mid-qualification (cnt=2), then full requalification with din held high
    for (int i = 1; i <= 4; i++) tick(1'b1);
    check("midq_busy_before", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("rst_midq");
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1);
      check($sformatf("requal%0d_q", i), q, (i >= 6));
      check($sformatf("requal%0d_rise", i), rise, (i == 6));
    end

    // Din toggling every two clocks must never reach acceptance
    for (int i = 0; i < 40; i++) begin
      tick(((i / 2) % 2) == 1);
      check($sformatf("tog%0d_q", i), q, 1'b1);
      check($sformatf("tog%0d_rise", i), rise, 1'b0);
      check($sformatf("tog%0d_fall", i), fall, 1'b0);
    end

    // Random held levels of varying length, one random reset midway
    for (int seg = 0; seg < 90; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) tick(lvl);
      if (seg == 45) begin
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("rst_rand");
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
